lru_ctrl: RTL and testbench
===========================

Name: lru_ctrl

Overview:
- Request/response controller that sits directly upstream of the 8192 x 3b pseudo-LRU regfile (lrurf) in the 4-way L1.
- Accepts one lookup per transaction with a handshake: set index, hit flag, and hit way.
- Reads the set's 3-bit PLRU state, selects either the hit way or the decoded victim, writes the updated PLRU state back through the regfile's way-encoded write port, and returns the selected way to the cache controller.
- Also sequences the regfile's synchronous clear after reset and keeps hit/miss statistics.

Parameters:
- INDEX_W, 13, set index width (8192 sets)
- INIT_CYCLES, 2, cycles lru_reset stays high after reset deasserts (min 1)
- CNT_W, 16, width of the saturating hit/miss counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept a request
- req_index  in  INDEX_W  set index
- req_hit  in  1  1 = tag hit in req_way, 0 = miss (victim wanted)
- req_way  in  4  one-hot hit way (ignored on miss)
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_way  out  4  one-hot way touched (hit way or victim)
- resp_miss  out  1  response is a victim selection
- resp_err  out  1  hit request carried a non-one-hot way
- lru_index  out  INDEX_W  regfile index
- lru_way  out  4  regfile one-hot way (update select)
- lru_wr  out  1  regfile write enable
- lru_q  in  3  regfile read data, combinational from lru_index
- lru_reset  out  1  synchronous clear to regfile
- hit_cnt  out  CNT_W  saturating count of valid hits
- miss_cnt  out  CNT_W  saturating count of misses, including error-demoted hits

Behaviour:
- FSM states: INIT, IDLE, LOOKUP, RESP.
- Reset (async) forces:
  - state=INIT, init counter=0
  - all response regs 0; hit_cnt=miss_cnt=0
  - held index/way/hit regs 0
- Reset value of every output:
  - lru_reset=1, lru_wr=0, lru_way=0, lru_index=0
  - req_ready=0, resp_valid=0, resp_way=0, resp_miss=0, resp_err=0
  - hit_cnt=0, miss_cnt=0
- lru_reset = reset OR (state==INIT). This guarantees at least one clk edge with the regfile clear asserted.
- INIT: counter increments each clk; after INIT_CYCLES cycles go to IDLE. While in INIT, req_ready=0 and lru_wr=0.
- IDLE: req_ready=1. On req_valid&req_ready:
  - latch index, hit, way
  - go to LOOKUP
- LOOKUP (exactly 1 cycle): lru_index = held index.
  - Valid hit = hit & (way is exactly one-hot).
  - Victim decode of lru_q: 000->way3, 001->way3, 010->way2, 011->way2, 100->way1, 101->way0, 110->way1, 111->way0.
  - Select: sel = valid hit ? held way : victim one-hot.
  - Regfile drive: lru_way=sel, lru_wr=1 (the only state driving lru_wr=1). The regfile commits its update at this clk edge.
  - Register the response: resp_way<=sel; resp_miss<=~valid hit; resp_err<=hit & ~one-hot.
  - Counters: increment hit_cnt or miss_cnt; each saturates at all-ones.
  - Go to RESP.
- RESP: resp_valid=1; response regs held stable until resp_ready.
  - On resp_ready: if req_valid, latch the new request and go to LOOKUP (back-to-back); else go to IDLE.
  - req_ready = resp_ready in RESP; 0 in LOOKUP.
- Latency and throughput:
  - Request accept to resp_valid: 2 clk.
  - Sustained throughput: 1 request per 2 clk.
- Hazards:
  - Read-modify-write happens within one LOOKUP cycle. Consecutive requests to the same index therefore always see the prior update; no forwarding is needed.
- Erroneous hits: a hit with way=0000 or multi-hot is treated as a miss (victim chosen, state updated) with resp_err=1.
- Reset asserted mid-transaction:
  - Immediately drops resp_valid and lru_wr and abandons the request.
  - On deassertion, the regfile is cleared again via INIT.
- X-safety: lru_way and resp_way never X. When not in LOOKUP, lru_way drives 0.

Test Plan:
- Reset release, then hold: lru_reset high for reset + INIT_CYCLES (2) clk; req_ready=0 until IDLE; no lru_wr pulses.
- After init, miss on index 0x0005 -> q=000, resp_way=1000, resp_miss=1, regfile state becomes 110. Second miss -> resp_way=0010, state 011. Third miss -> resp_way=0100.
- Hit on index 0x1FFF with way=0001 after state 111 -> resp_way=0001, resp_miss=0, written state 010, hit_cnt+1.
- Hit with req_way=0110 on a fresh set -> resp_way=1000, resp_miss=1, resp_err=1, miss_cnt+1.
- Back-to-back: req_valid held with resp_ready=1 for 8 requests -> one response per 2 clk. With resp_ready held low 5 clk, resp_way is stable and req_ready=0.
- Async reset asserted during LOOKUP -> outputs at reset values in the same cycle, lru_wr=0; after release, INIT repeats and counters read 0.

Source files
------------

// File: rtl/lru_ctrl.sv
// Request/response front end for the 4-way L1 pseudo-LRU regfile (lrurf).
// Resolves hit way or PLRU victim, writes the update back, and keeps hit/miss stats.
module lru_ctrl #(
  parameter int INDEX_W     = 13,
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [INDEX_W-1:0] req_index,
  input  logic               req_hit,
  input  logic [3:0]         req_way,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [3:0]         resp_way,
  output logic               resp_miss,
  output logic               resp_err,
  output logic [INDEX_W-1:0] lru_index,
  output logic [3:0]         lru_way,
  output logic               lru_wr,
  input  logic [2:0]         lru_q,
  output logic               lru_reset,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    LOOKUP = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              r_state;
  logic [INIT_W-1:0]   r_initCnt;
  logic [INDEX_W-1:0]  r_index;
  logic                r_hit;
  logic [3:0]          r_way;
  logic                r_respValid;
  logic [3:0]          r_respWay;
  logic                r_respMiss;
  logic                r_respErr;
  logic [CNT_W-1:0]    r_hitCnt;
  logic [CNT_W-1:0]    r_missCnt;

  logic                w_oneHot;
  logic                w_validHit;
  logic [3:0]          w_victim;
  logic [3:0]          w_sel;
  logic                w_inLookup;

  assign w_oneHot   = (r_way != 4'd0) && ((r_way & (r_way - 4'd1)) == 4'd0);
  assign w_validHit = r_hit & w_oneHot;
  assign w_inLookup = (r_state == LOOKUP);

  // Tree PLRU: bit 2 picks the half, bit 1 picks within ways 2/3, bit 0 within ways 0/1.
  always_comb begin
    w_victim = 4'b0001;
    case (lru_q)
      3'b000, 3'b001: w_victim = 4'b1000;
      3'b010, 3'b011: w_victim = 4'b0100;
      3'b100, 3'b110: w_victim = 4'b0010;
      default:        w_victim = 4'b0001;
    endcase
  end

  assign w_sel = w_validHit ? r_way : w_victim;

  always_comb begin
    req_ready = 1'b0;
    case (r_state)
      IDLE:    req_ready = 1'b1;
      RESP:    req_ready = resp_ready;
      default: req_ready = 1'b0;
    endcase
  end

  assign lru_reset  = reset | (r_state == INIT);
  assign lru_index  = r_index;
  assign lru_wr     = w_inLookup;
  assign lru_way    = w_inLookup ? w_sel : 4'd0;

  assign resp_valid = r_respValid;
  assign resp_way   = r_respWay;
  assign resp_miss  = r_respMiss;
  assign resp_err   = r_respErr;
  assign hit_cnt    = r_hitCnt;
  assign miss_cnt   = r_missCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= INIT;
      r_initCnt   <= '0;
      r_index     <= '0;
      r_hit       <= 1'b0;
      r_way       <= 4'd0;
      r_respValid <= 1'b0;
      r_respWay   <= 4'd0;
      r_respMiss  <= 1'b0;
      r_respErr   <= 1'b0;
      r_hitCnt    <= '0;
      r_missCnt   <= '0;
    end else begin
      case (r_state)
        INIT: begin
          if (r_initCnt == INIT_W'(INIT_CYCLES - 1)) begin
            r_state <= IDLE;
          end else begin
            r_initCnt <= r_initCnt + INIT_W'(1);
          end
        end
        IDLE: begin
          if (req_valid) begin
            r_index <= req_index;
            r_hit   <= req_hit;
            r_way   <= req_way;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_respValid <= 1'b1;
          r_respWay   <= w_sel;
          r_respMiss  <= ~w_validHit;
          r_respErr   <= r_hit & ~w_oneHot;
          if (w_validHit) begin
            if (r_hitCnt != '1) r_hitCnt <= r_hitCnt + CNT_W'(1);
          end else begin
            if (r_missCnt != '1) r_missCnt <= r_missCnt + CNT_W'(1);
          end
          r_state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_respValid <= 1'b0;
            // A waiting request is taken in the same edge so throughput stays one per two cycles.
            if (req_valid) begin
              r_index <= req_index;
              r_hit   <= req_hit;
              r_way   <= req_way;
              r_state <= LOOKUP;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lru_ctrl.sv
// Self-checking bench for lru_ctrl: behavioural PLRU regfile plus a scoreboard of expected responses.
module tb_lru_ctrl;

  localparam int INDEX_W     = 13;
  localparam int INIT_CYCLES = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int SETS        = 1 << INDEX_W;

  logic               clk;
  logic               reset;
  logic               req_valid;
  logic               req_ready;
  logic [INDEX_W-1:0] req_index;
  logic               req_hit;
  logic [3:0]         req_way;
  logic               resp_valid;
  logic               resp_ready;
  logic [3:0]         resp_way;
  logic               resp_miss;
  logic               resp_err;
  logic [INDEX_W-1:0] lru_index;
  logic [3:0]         lru_way;
  logic               lru_wr;
  logic [2:0]         lru_q;
  logic               lru_reset;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;

  lru_ctrl #(
    .INDEX_W(INDEX_W),
    .INIT_CYCLES(INIT_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_index(req_index),
    .req_hit(req_hit),
    .req_way(req_way),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_way(resp_way),
    .resp_miss(resp_miss),
    .resp_err(resp_err),
    .lru_index(lru_index),
    .lru_way(lru_way),
    .lru_wr(lru_wr),
    .lru_q(lru_q),
    .lru_reset(lru_reset),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  int checkTotal  = 0;
  int checkPassed = 0;

  logic [5:0]   expQ[$];
  logic [2:0]   modelState[int];
  int           expHits   = 0;
  int           expMisses = 0;
  int           lastAcceptCycle = 0;
  logic [5:0]   monExp;
  logic [3:0]   lastRespWay  = 4'd0;
  logic         lastRespMiss = 1'b0;
  logic         lastRespErr  = 1'b0;

  function automatic logic [3:0] victimOf(input logic [2:0] s);
    case (s)
      3'b000, 3'b001: return 4'b1000;
      3'b010, 3'b011: return 4'b0100;
      3'b100, 3'b110: return 4'b0010;
      default:        return 4'b0001;
    endcase
  endfunction

  function automatic logic [2:0] touchState(input logic [2:0] s, input logic [3:0] w);
    case (w)
      4'b0001: return {1'b0, s[1], 1'b0};
      4'b0010: return {1'b0, s[1], 1'b1};
      4'b0100: return {1'b1, 1'b0, s[0]};
      4'b1000: return {1'b1, 1'b1, s[0]};
      default: return s;
    endcase
  endfunction

  // Behavioural lrurf: synchronous clear, way-encoded PLRU update, combinational read.
  logic [2:0] lruMem [0:SETS-1];
  always @(posedge clk) begin
    if (lru_reset) begin
      for (int i = 0; i < SETS; i++) lruMem[i] <= 3'b000;
    end else if (lru_wr) begin
      lruMem[lru_index] <= touchState(lruMem[lru_index], lru_way);
    end
  end
  assign lru_q = lruMem[lru_index];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkTotal++;
    if (observed === expected) checkPassed++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic modelRequest(input logic [INDEX_W-1:0] idx, input logic hit, input logic [3:0] way);
    logic [2:0] s;
    logic       valid;
    logic [3:0] sel;
    s     = modelState.exists(int'(idx)) ? modelState[int'(idx)] : 3'b000;
    valid = hit && ($countones(way) == 1);
    sel   = valid ? way : victimOf(s);
    modelState[int'(idx)] = touchState(s, sel);
    if (valid) begin
      if (expHits < CNT_MAX) expHits++;
    end else begin
      if (expMisses < CNT_MAX) expMisses++;
    end
    expQ.push_back({sel, ~valid, hit & ~valid});
  endtask

  // Drives one request and returns one time unit after the edge that accepted it.
  task automatic applyStimulus(input logic [INDEX_W-1:0] idx, input logic hit, input logic [3:0] way);
    bit accepted = 1'b0;
    req_index = idx;
    req_hit   = hit;
    req_way   = way;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1'b1;
        modelRequest(idx, hit, way);
      end
    end
    if (!accepted) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
    #1;
    lastAcceptCycle = cycleCount;
  endtask

  task automatic waitDrain();
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 40 && (expQ.size() != 0 || resp_valid); i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drainQueue", expQ.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("respUnexpected", 32'd1, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("respWay", resp_way, monExp[5:2]);
        checkOutput("respMiss", resp_miss, monExp[1]);
        checkOutput("respErr", resp_err, monExp[0]);
      end
      lastRespWay  = resp_way;
      lastRespMiss = resp_miss;
      lastRespErr  = resp_err;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prevAccept;
    logic [INDEX_W-1:0] rIdx;
    logic               rHit;
    logic [3:0]         rWay;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_index  = '0;
    req_hit    = 1'b0;
    req_way    = 4'd0;
    resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstLruReset", lru_reset, 32'd1);
    checkOutput("rstLruWr", lru_wr, 32'd0);
    checkOutput("rstLruWay", lru_way, 32'd0);
    checkOutput("rstLruIndex", lru_index, 32'd0);
    checkOutput("rstReqReady", req_ready, 32'd0);
    checkOutput("rstRespValid", resp_valid, 32'd0);
    checkOutput("rstRespWay", resp_way, 32'd0);
    checkOutput("rstRespMiss", resp_miss, 32'd0);
    checkOutput("rstRespErr", resp_err, 32'd0);
    checkOutput("rstHitCnt", hit_cnt, 32'd0);
    checkOutput("rstMissCnt", miss_cnt, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("init1LruReset", lru_reset, 32'd1);
    checkOutput("init1ReqReady", req_ready, 32'd0);
    checkOutput("init1LruWr", lru_wr, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("init2LruReset", lru_reset, 32'd0);
    checkOutput("init2ReqReady", req_ready, 32'd1);

    applyStimulus(13'h0005, 1'b0, 4'b0000);
    req_valid = 1'b0;
    checkOutput("lookupWr", lru_wr, 32'd1);
    checkOutput("lookupIndex", lru_index, 32'h5);
    checkOutput("lookupWay", lru_way, 32'b1000);
    checkOutput("lookupRespValid", resp_valid, 32'd0);
    checkOutput("lookupReqReady", req_ready, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("respLatency", resp_valid, 32'd1);
    checkOutput("respLruWr", lru_wr, 32'd0);
    checkOutput("respLruWay", lru_way, 32'd0);
    waitDrain();
    checkOutput("miss1Way", lastRespWay, 32'b1000);
    checkOutput("miss1Flag", lastRespMiss, 32'd1);
    checkOutput("miss1State", lruMem[5], 32'b110);

    applyStimulus(13'h0005, 1'b0, 4'b0000);
    waitDrain();
    checkOutput("miss2Way", lastRespWay, 32'b0010);
    checkOutput("miss2State", lruMem[5], 32'b011);

    applyStimulus(13'h0005, 1'b0, 4'b0000);
    waitDrain();
    checkOutput("miss3Way", lastRespWay, 32'b0100);
    checkOutput("missCnt3", miss_cnt, 32'd3);
    checkOutput("hitCnt0", hit_cnt, 32'd0);

    applyStimulus(13'h1FFF, 1'b1, 4'b0010);
    applyStimulus(13'h1FFF, 1'b1, 4'b1000);
    waitDrain();
    checkOutput("preHitState", lruMem[13'h1FFF], 32'b111);
    applyStimulus(13'h1FFF, 1'b1, 4'b0001);
    waitDrain();
    checkOutput("hitWay", lastRespWay, 32'b0001);
    checkOutput("hitMiss", lastRespMiss, 32'd0);
    checkOutput("hitState", lruMem[13'h1FFF], 32'b010);
    checkOutput("hitCnt3", hit_cnt, 32'd3);

    applyStimulus(13'h0100, 1'b1, 4'b0110);
    waitDrain();
    checkOutput("errWay", lastRespWay, 32'b1000);
    checkOutput("errMiss", lastRespMiss, 32'd1);
    checkOutput("errFlag", lastRespErr, 32'd1);
    checkOutput("errMissCnt", miss_cnt, 32'd4);
    checkOutput("errHitCnt", hit_cnt, 32'd3);

    resp_ready = 1'b1;
    prevAccept = 0;
    for (int i = 0; i < 20; i++) begin
      rIdx = INDEX_W'($urandom_range(0, 3));
      rHit = (i % 4 == 0);
      if (!rHit) rWay = 4'd0;
      else if ($urandom_range(0, 3) == 0) rWay = 4'($urandom);
      else rWay = 4'b0001 << $urandom_range(0, 3);
      applyStimulus(rIdx, rHit, rWay);
      if (i > 0) checkOutput("burstSpacing", lastAcceptCycle - prevAccept, 32'd2);
      prevAccept = lastAcceptCycle;
    end
    waitDrain();
    checkOutput("burstHitCnt", hit_cnt, expHits);
    checkOutput("burstMissCnt", miss_cnt, expMisses);
    checkOutput("missCntSaturated", miss_cnt, CNT_MAX);
    for (int i = 0; i < 4; i++) begin
      checkOutput("burstState", lruMem[i], modelState.exists(i) ? modelState[i] : 3'b000);
    end

    resp_ready = 1'b0;
    applyStimulus(13'h0042, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stallValid", resp_valid, 32'd1);
      checkOutput("stallWay", resp_way, 32'b1000);
      checkOutput("stallReqReady", req_ready, 32'd0);
    end
    resp_ready = 1'b1;
    applyStimulus(13'h0042, 1'b0, 4'b0000);
    waitDrain();
    checkOutput("sameIndexWay", lastRespWay, 32'b0010);

    applyStimulus(13'h0009, 1'b0, 4'b0000);
    req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstLruWr", lru_wr, 32'd0);
    checkOutput("midRstLruWay", lru_way, 32'd0);
    checkOutput("midRstRespValid", resp_valid, 32'd0);
    checkOutput("midRstLruReset", lru_reset, 32'd1);
    checkOutput("midRstReqReady", req_ready, 32'd0);
    checkOutput("midRstHitCnt", hit_cnt, 32'd0);
    checkOutput("midRstMissCnt", miss_cnt, 32'd0);
    expQ.delete();
    modelState.delete();
    expHits   = 0;
    expMisses = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reinit1LruReset", lru_reset, 32'd1);
    checkOutput("reinit1ReqReady", req_ready, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("reinit2LruReset", lru_reset, 32'd0);
    checkOutput("reinit2ReqReady", req_ready, 32'd1);
    checkOutput("reinitHitCnt", hit_cnt, 32'd0);
    checkOutput("reinitMissCnt", miss_cnt, 32'd0);
    checkOutput("reinitCleared", lruMem[5], 32'd0);

    applyStimulus(13'h0005, 1'b0, 4'b0000);
    waitDrain();
    checkOutput("postRstWay", lastRespWay, 32'b1000);
    checkOutput("postRstMissCnt", miss_cnt, 32'd1);

    $display("%0d/%0d checks passed", checkPassed, checkTotal);
    $finish;
  end

endmodule
